// File: rtl/ram_loader_pkg.sv
// Shared definitions for the program-image RAM loader (bus widths, RAM depth, FSM states).
// The optional checksum trailer is compiled in when LOADER_CHECKSUM_EN is defined.
package ram_loader_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_DATA_W = 32;
  localparam int unsigned RAM_NUM     = 4096;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/ram_loader_byte_word_packer.sv
// Packs an accepted byte stream into little-endian 32-bit words; word_full marks the 4th byte.
// The word output already includes the byte being accepted, so it is valid while word_full=1.
module ram_loader_byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  cnt;
  logic [23:0] sr;  // only the three earlier bytes need storing

  assign word      = {byte_in, sr};
  assign word_full = shift && (cnt == 2'd3);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n || clear) begin
      cnt <= 2'd0;
      sr  <= 24'd0;
    end else if (shift) begin
      cnt <= cnt + 2'd1;
      sr  <= {byte_in, sr[23:8]};
    end
  end

endmodule

// File: rtl/ram_loader.sv
// Loads a length-prefixed program image from a UART byte stream into RAM, one write per word.
// Define LOADER_CHECKSUM_EN to append a one-byte XOR checksum after the payload.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WORD_NUM  = RAM_NUM
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   rx_valid_i,
  input  logic [7:0]             rx_data_i,
  output logic                   rx_ready_o,
  output logic                   wr_en_o,
  output logic [INST_ADDR_W-1:0] addr_o,
  output logic [INST_DATA_W-1:0] data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_PAYLOAD = CSUM;
  logic [7:0] csum;
`else
  localparam state_t AFTER_PAYLOAD = DONE;
`endif

  state_t      state, state_nxt;
  logic        accept, start_ok, word_full, last_word;
  logic [31:0] word, len, idx;

  assign rx_ready_o = state inside {LEN, DATA, CSUM};
  assign wr_en_o    = (state == WRITE);
  assign busy_o     = state inside {LEN, DATA, WRITE, CSUM};
  assign done_o     = (state == DONE);

  assign accept    = rx_valid_i && rx_ready_o;
  assign start_ok  = (state == IDLE) && start_i;
  assign last_word = (idx + 32'd1) == len;

  ram_loader_byte_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .shift     (accept && (state != CSUM)),
    .byte_in   (rx_data_i),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:  if (start_i) state_nxt = LEN;
      LEN: begin
        if (word_full) begin
          if (word == 32'd0)         state_nxt = AFTER_PAYLOAD;
          else if (word > WORD_NUM)  state_nxt = IDLE;
          else                       state_nxt = DATA;
        end
      end
      DATA:  if (word_full) state_nxt = WRITE;
      WRITE: state_nxt = last_word ? AFTER_PAYLOAD : DATA;
      CSUM:  if (accept) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address and data are captured as the word completes, so they are stable in WRITE
  // and hold their value afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len    <= 32'd0;
      idx    <= 32'd0;
      addr_o <= 32'd0;
      data_o <= 32'd0;
      err_o  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum   <= 8'd0;
`endif
    end else begin
      if (start_ok) begin
        len   <= 32'd0;
        idx   <= 32'd0;
        err_o <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum  <= 8'd0;
`endif
      end
      if (state == LEN && word_full) begin
        len <= word;
        if (word > WORD_NUM) err_o <= 1'b1;
      end
      if (state == DATA && word_full) begin
        addr_o <= BASE_ADDR + (idx << 2);
        data_o <= word;
      end
      if (state == WRITE) idx <= idx + 32'd1;
`ifdef LOADER_CHECKSUM_EN
      if (state == DATA && accept) csum <= csum ^ rx_data_i;
      if (state == CSUM && accept && rx_data_i != csum) err_o <= 1'b1;
`endif
    end
  end

endmodule
